// File: rtl/vcmp_pkg.sv
// vcmp_pkg: shared definitions for the vector compare pipeline.
//   OP_W     : width of the operation code
//   cmp_op_e : the eight compare / min / max operations
package vcmp_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LT  = 3'd2,
    OP_LE  = 3'd3,
    OP_GT  = 3'd4,
    OP_GE  = 3'd5,
    OP_MIN = 3'd6,
    OP_MAX = 3'd7
  } cmp_op_e;

endpackage

// File: rtl/CKLNQD12.sv
// CKLNQD12: behavioural model of the latch-based integrated clock gate cell.
//   TE : test enable (ORed with E)
//   E  : functional enable
//   CP : free-running clock
//   Q  : gated clock
// The enable is captured while CP is low, so a change on E/TE only affects
// the next rising edge of CP and Q never glitches.
module CKLNQD12 (
  input  logic TE,
  input  logic E,
  input  logic CP,
  output logic Q
);

  logic en_l;

  always_latch begin
    if (!CP) en_l <= E | TE;
  end

  assign Q = CP & en_l;

endmodule

// File: rtl/vcmp_lane.sv
// vcmp_lane: combinational single-lane compare / select.
//   a_i, b_i  : lane operands
//   op_i      : operation
//   tc_i      : 1 = signed ordering, 0 = unsigned ordering
//   active_i  : lane mask bit; inactive lanes give flag 0 and pass a_i through
//   flag_o    : predicate result (MIN: a<b, MAX: a>b)
//   res_o     : MIN/MAX result, 0 for plain compares
module vcmp_lane
  import vcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  cmp_op_e               op_i,
  input  logic                  tc_i,
  input  logic                  active_i,
  output logic                  flag_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] a_key;
  logic [DATA_WIDTH-1:0] b_key;
  logic                  lt;
  logic                  eq;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  assign a_key = {a_i[MSB] ^ tc_i, a_i[MSB-1:0]};
  assign b_key = {b_i[MSB] ^ tc_i, b_i[MSB-1:0]};
  assign lt    = (a_key < b_key);
  assign eq    = (a_i == b_i);

  always_comb begin
    flag_o = 1'b0;
    res_o  = '0;
    unique case (op_i)
      OP_EQ:  flag_o = eq;
      OP_NE:  flag_o = ~eq;
      OP_LT:  flag_o = lt;
      OP_LE:  flag_o = lt | eq;
      OP_GT:  flag_o = ~(lt | eq);
      OP_GE:  flag_o = ~lt;
      OP_MIN: begin
        flag_o = lt;
        res_o  = (lt | eq) ? a_i : b_i;
      end
      OP_MAX: begin
        flag_o = ~(lt | eq);
        res_o  = lt ? b_i : a_i;
      end
    endcase
    if (!active_i) begin
      flag_o = 1'b0;
      res_o  = a_i;
    end
  end

endmodule

// File: rtl/vcmp_pipe.sv
// vcmp_pipe: two-stage, multi-lane vector compare / min / max unit.
//   module_clk_i : free-running clock, gated internally by en_i
//   rst_i        : asynchronous active-high reset (flushes the pipe)
//   en_i         : module enable; closes the clock gate and blocks ready_o
//   valid_i/ready_o : input beat handshake (op_i, tc_i, mask_i, a_i, b_i)
//   valid_o/ready_i : result handshake (flag_o, res_o, any_o, all_o)
//
// Handshake: a beat moves across an interface on a clock edge where both
// valid and ready are high at that edge; valid and its payload must stay
// stable until that happens. The pipeline stalls globally whenever a
// result is presented and not taken; during a stall both stages hold.
module vcmp_pipe
  import vcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
) (
  input  logic                        module_clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [OP_W-1:0]             op_i,
  input  logic                        tc_i,
  input  logic [LANES-1:0]            mask_i,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LANES-1:0]            flag_o,
  output logic [LANES*DATA_WIDTH-1:0] res_o,
  output logic                        any_o,
  output logic                        all_o
);

  localparam int VW = LANES * DATA_WIDTH;

  logic gclk;
  logic stall;
  logic accept;

  // Stage 1: operands and control
  logic             s1_valid_q;
  cmp_op_e          s1_op_q;
  logic             s1_tc_q;
  logic [LANES-1:0] s1_mask_q;
  logic [VW-1:0]    s1_a_q;
  logic [VW-1:0]    s1_b_q;

  // Stage 1 combinational results
  logic [LANES-1:0] flag_d;
  logic [VW-1:0]    res_d;
  logic             any_d;
  logic             all_d;

  // Stage 2: results
  logic             s2_valid_q;
  logic [LANES-1:0] s2_flag_q;
  logic [VW-1:0]    s2_res_q;
  logic             s2_any_q;
  logic             s2_all_q;

  CKLNQD12 u_icg (
    .TE (en_i),
    .E  (en_i),
    .CP (module_clk_i),
    .Q  (gclk)
  );

  assign stall   = s2_valid_q & ~ready_i;
  assign ready_o = en_i & ~stall;
  assign accept  = valid_i & ready_o;

  always_ff @(posedge gclk or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_EQ;
      s1_tc_q    <= 1'b0;
      s1_mask_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q   <= cmp_op_e'(op_i);
        s1_tc_q   <= tc_i;
        s1_mask_q <= mask_i;
        s1_a_q    <= a_i;
        s1_b_q    <= b_i;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vcmp_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .a_i      (s1_a_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .b_i      (s1_b_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .op_i     (s1_op_q),
      .tc_i     (s1_tc_q),
      .active_i (s1_mask_q[i]),
      .flag_o   (flag_d[i]),
      .res_o    (res_d[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Inactive lanes already carry flag 0, so they only need to be excused
  // from the AND; an empty mask therefore yields all=1.
  assign any_d = |flag_d;
  assign all_d = &(flag_d | ~s1_mask_q);

  always_ff @(posedge gclk or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_flag_q  <= '0;
      s2_res_q   <= '0;
      s2_any_q   <= 1'b0;
      s2_all_q   <= 1'b0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_flag_q <= flag_d;
        s2_res_q  <= res_d;
        s2_any_q  <= any_d;
        s2_all_q  <= all_d;
      end
    end
  end

  assign valid_o = s2_valid_q;
  assign flag_o  = s2_flag_q;
  assign res_o   = s2_res_q;
  assign any_o   = s2_any_q;
  assign all_o   = s2_all_q;

endmodule

// File: tb/tb_vcmp_pipe.sv
// tb_vcmp_pipe: self-checking bench for vcmp_pipe (LANES=4, DATA_WIDTH=32).
// Expected results come from an arithmetic reference model; accepted beats
// are queued and every presented result is compared against the queue head.
module tb_vcmp_pipe;

  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int VW    = LANES * DW;
  localparam int W     = LANES + VW + 2;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i   = 1'b1;
  logic             en_i    = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [2:0]       op_i    = '0;
  logic             tc_i    = 1'b0;
  logic [LANES-1:0] mask_i  = '0;
  logic [VW-1:0]    a_i     = '0;
  logic [VW-1:0]    b_i     = '0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [LANES-1:0] flag_o;
  logic [VW-1:0]    res_o;
  logic             any_o;
  logic             all_o;

  vcmp_pipe #(
    .DATA_WIDTH (DW),
    .LANES      (LANES)
  ) dut (
    .module_clk_i (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op_i         (op_i),
    .tc_i         (tc_i),
    .mask_i       (mask_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .flag_o       (flag_o),
    .res_o        (res_o),
    .any_o        (any_o),
    .all_o        (all_o)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int n_consumed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic longint to_num(input logic [DW-1:0] e, input logic tc);
    longint v;
    v = longint'(e);
    if (tc && e[DW-1]) v = v - (longint'(1) << DW);
    return v;
  endfunction

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic tc,
                                         input logic [LANES-1:0] mask,
                                         input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [LANES-1:0] flag;
    logic [VW-1:0]    res;
    logic             any_v, all_v, f;
    logic [DW-1:0]    ae, be, r;
    longint           av, bv;
    flag = '0; res = '0; any_v = 1'b0; all_v = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      ae = a[i*DW +: DW];
      be = b[i*DW +: DW];
      av = to_num(ae, tc);
      bv = to_num(be, tc);
      f  = 1'b0;
      r  = '0;
      case (op)
        3'd0: f = (av == bv);
        3'd1: f = (av != bv);
        3'd2: f = (av <  bv);
        3'd3: f = (av <= bv);
        3'd4: f = (av >  bv);
        3'd5: f = (av >= bv);
        3'd6: begin f = (av < bv); r = (av <= bv) ? ae : be; end
        default: begin f = (av > bv); r = (av >= bv) ? ae : be; end
      endcase
      if (!mask[i]) begin
        f = 1'b0;
        r = ae;
      end
      flag[i] = f;
      res[i*DW +: DW] = r;
      any_v = any_v | f;
      if (mask[i]) all_v = all_v & f;
    end
    return {flag, res, any_v, all_v};
  endfunction

  function automatic logic [VW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [VW-1:0] v;
    v[0*DW +: DW] = l0;
    v[1*DW +: DW] = l1;
    v[2*DW +: DW] = l2;
    v[3*DW +: DW] = l3;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_elem(input logic [DW-1:0] other);
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return DW'($urandom_range(0, 3));
      2: return ~DW'($urandom_range(0, 3));
      3: return other;
      default: return 32'h8000_0000 | DW'($urandom_range(0, 1));
    endcase
  endfunction

  // scoreboard / monitor: sampled mid-cycle, acts on the next rising edge.
  // With en_i low the clock is gated, so nothing is consumed then.
  always @(negedge clk) begin
    if (!rst_i) begin
      check("ready_o", W'(ready_o), W'(en_i & ~(valid_o & ~ready_i)));
      if (valid_o) begin
        if (exp_q.size() == 0) check("no_stale", W'(valid_o), '0);
        else check("result", {flag_o, res_o, any_o, all_o}, exp_q[0]);
      end
      if (valid_o && ready_i && en_i && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_consumed++;
      end
      if (valid_i && ready_o) exp_q.push_back(model(op_i, tc_i, mask_i, a_i, b_i));
    end
  end

  // driver tasks: called and return at 1ns after a rising edge
  task automatic send(input logic [2:0] op, input logic tc, input logic [LANES-1:0] mask,
                      input logic [VW-1:0] a, input logic [VW-1:0] b);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    valid_i = 1'b1; op_i = op; tc_i = tc; mask_i = mask; a_i = a; b_i = b;
    while (!done) begin
      @(negedge clk);
      done = ready_o;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        check("send_timeout", '0, W'(1));
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic [VW-1:0] a, b;
    for (int i = 0; i < LANES; i++) begin
      a[i*DW +: DW] = rand_elem(DW'($urandom));
      b[i*DW +: DW] = rand_elem(a[i*DW +: DW]);
    end
    send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), LANES'($urandom_range(0, 15)), a, b);
  endtask

  // one beat into an idle pipe, with the two-edge latency checked
  task automatic run_one(input logic [2:0] op, input logic tc, input logic [LANES-1:0] mask,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output logic [W-1:0] obs);
    send(op, tc, mask, a, b);
    @(negedge clk);
    check("lat_edge1", W'(valid_o), '0);
    @(negedge clk);
    check("lat_edge2", W'(valid_o), W'(1));
    obs = {flag_o, res_o, any_o, all_o};
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", W'(exp_q.size()), '0);
  endtask

  logic [W-1:0] obs;
  int           cons0;
  bit           rand_done;

  initial begin
    // reset state
    #2;
    check("rst_valid", W'(valid_o), '0);
    check("rst_outputs", {flag_o, res_o, any_o, all_o}, '0);
    check("rst_ready_en1", W'(ready_o), W'(1));
    en_i = 1'b0;
    #1;
    check("rst_ready_en0", W'(ready_o), '0);
    en_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    // signed vs unsigned
    run_one(3'd2, 1'b1, 4'b1111, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, obs);
    check("lt_signed", {obs[W-1 -: LANES], obs[1], obs[0]}, W'({4'b1111, 1'b1, 1'b1}));
    run_one(3'd2, 1'b0, 4'b1111, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, obs);
    check("lt_unsigned", {obs[W-1 -: LANES], obs[0]}, W'({4'b0000, 1'b0}));

    // MIN / MAX
    run_one(3'd6, 1'b1, 4'b1111, pack4(5, -3, 7, 7), pack4(2, 4, 7, -1), obs);
    check("min_res", W'(obs[W-1-LANES -: VW]), W'(pack4(2, -3, 7, -1)));
    check("min_flag", W'(obs[W-1 -: LANES]), W'(4'b0010));
    run_one(3'd7, 1'b1, 4'b1111, pack4(5, -3, 7, 7), pack4(2, 4, 7, -1), obs);
    check("max_res", W'(obs[W-1-LANES -: VW]), W'(pack4(5, 4, 7, 7)));

    // masking
    run_one(3'd0, 1'b0, 4'b0101, pack4(11, 22, 33, 44), pack4(11, 22, 33, 44), obs);
    check("mask_flag_all", {obs[W-1 -: LANES], obs[0]}, W'({4'b0101, 1'b1}));
    check("mask_res", W'(obs[W-1-LANES -: VW]), W'(pack4(0, 22, 0, 44)));

    // empty mask
    run_one(3'd5, 1'b1, 4'b0000, pack4(1, 2, 3, 4), pack4(0, 9, 3, -7), obs);
    check("empty_mask", {obs[W-1 -: LANES], obs[1], obs[0]}, W'({4'b0000, 1'b0, 1'b1}));
    check("empty_res", W'(obs[W-1-LANES -: VW]), W'(pack4(1, 2, 3, 4)));

    // backpressure: six beats back to back, ready_i low on cycles 3..5
    cons0 = n_consumed;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          ready_i = !(c >= 3 && c <= 5);
          @(negedge clk);
          check("bp_ready", W'(ready_o), W'(!(c >= 3 && c <= 5)));
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check("bp_count", W'(n_consumed - cons0), W'(6));

    // enable low with two beats in flight
    cons0 = n_consumed;
    send_rand();
    send_rand();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_hold_valid", W'(valid_o), W'(1));
      check("en_hold_ready", W'(ready_o), '0);
      @(posedge clk); #1;
    end
    en_i = 1'b1;
    drain();
    check("en_count", W'(n_consumed - cons0), W'(2));

    // reset mid-stream
    send_rand();
    send_rand();
    send_rand();
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_valid", W'(valid_o), '0);
    check("midrst_outputs", {flag_o, res_o, any_o, all_o}, '0);
    check("midrst_ready", W'(ready_o), W'(1));
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", W'(valid_o), '0);
      @(posedge clk); #1;
    end

    // randomized stream with random backpressure and enable
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) send_rand();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          ready_i = ($urandom_range(0, 3) != 0);
          en_i    = ($urandom_range(0, 7) != 0);
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
        en_i    = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

endmodule
